axi_burst_sequencer: RTL and testbench

- Takes one host transfer request (direction, start address, word count) and splits it into AXI bursts of at most MAX_BURST beats.
- No burst crosses a 4 KB boundary.
- Hands each burst descriptor to the AXI master channel engine and tracks completion, error responses and timeout.
- Sits between the command parser (after header decode) and the AW/W/B and AR/R channel logic, and replaces ad-hoc single-burst sequencing.

---
 rtl/axi_burst_sequencer_pkg.sv | 28 ++
 rtl/axi_seq_len_calc.sv | 29 ++
 rtl/axi_burst_sequencer.sv | 175 +++++++++++++++++
 tb/tb_axi_burst_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_sequencer_pkg.sv
// Shared encodings for the AXI burst sequencer: FSM states, status codes,
// AXI burst/response codes and the 4 KB boundary size.
package axi_seq_defines;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_SLVERR  = 2'b01;
  localparam logic [1:0] STAT_DECERR  = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/axi_seq_len_calc.sv
// Burst length for the next burst: min(remaining, MAX_BURST, beats left
// before the next 4 KB boundary); the boundary limit applies only to INCR.
module axi_seq_len_calc
  import axi_seq_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic [11:0] addr_i,
  input  logic [31:0] remaining_i,
  input  logic        auto_inc_i,
  output logic [4:0]  len_beats_o
);

  localparam int BPB_LOG2 = $clog2(DATA_WIDTH / 8);

  logic [12:0] room_bytes;
  logic [12:0] room_beats;
  logic [31:0] cap;

  always_comb begin
    room_bytes = 13'(BOUNDARY_BYTES) - {1'b0, addr_i};
    room_beats = room_bytes >> BPB_LOG2;
    cap        = 32'(MAX_BURST);
    if (auto_inc_i && (32'(room_beats) < cap)) cap = 32'(room_beats);
    len_beats_o = (remaining_i < cap) ? 5'(remaining_i) : 5'(cap);
  end

endmodule

// File: rtl/axi_burst_sequencer.sv
// Splits one host transfer into AXI bursts (<= MAX_BURST beats, no 4 KB
// crossing) and tracks completion. Optional per-burst abort: AXI_BURST_SEQ_TIMEOUT_EN.
module axi_burst_sequencer
  import axi_seq_defines::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MAX_BURST       = 16,
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'd100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_stb,
  output logic                  o_cmd_rdy,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_count,
  input  logic                  i_cmd_auto_inc,
  input  logic [31:0]           i_timeout,
  output logic                  o_burst_valid,
  input  logic                  i_burst_ready,
  output logic                  o_burst_write,
  output logic [ADDR_WIDTH-1:0] o_burst_addr,
  output logic [3:0]            o_burst_len,
  output logic [1:0]            o_burst_type,
  input  logic                  i_burst_done,
  input  logic [1:0]            i_burst_resp,
  output logic                  o_busy,
  output logic                  o_done_stb,
  output logic [1:0]            o_status,
  output logic [31:0]           o_beats_done
);

  localparam int BPB_LOG2 = $clog2(DATA_WIDTH / 8);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           rem_q, rem_d;
  logic [3:0]            blen_q, blen_d;
  logic                  write_q, write_d;
  logic                  inc_q, inc_d;
  logic [1:0]            status_q, status_d;
  logic [31:0]           beats_q, beats_d;
  logic [4:0]            calc_len;
  logic [4:0]            cur_beats;

  axi_seq_len_calc #(.DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) u_len (
    .addr_i      (addr_q[11:0]),
    .remaining_i (rem_q),
    .auto_inc_i  (inc_q),
    .len_beats_o (calc_len)
  );

  assign cur_beats = {1'b0, blen_q} + 5'd1;

`ifdef AXI_BURST_SEQ_TIMEOUT_EN
  logic [31:0] tmo_load_q, tmo_load_d;
  logic [31:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^{i_timeout, DEFAULT_TIMEOUT};
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    write_d  = write_q;
    inc_d    = inc_q;
    status_d = status_q;
    beats_d  = beats_q;
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
    tmo_load_d = tmo_load_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: if (i_cmd_stb) begin
        addr_d   = i_cmd_addr;
        rem_d    = i_cmd_count;
        write_d  = i_cmd_write;
        inc_d    = i_cmd_auto_inc;
        status_d = STAT_OK;
        beats_d  = '0;
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
        tmo_load_d = (i_timeout == '0) ? DEFAULT_TIMEOUT : i_timeout;
`endif
        state_d  = ST_CALC;
      end
      // A zero-length request passes through CALC so done keeps the same latency
      ST_CALC: if (rem_q == '0) begin
        state_d = ST_DONE;
      end else begin
        blen_d  = 4'(calc_len - 5'd1);
        state_d = ST_ISSUE;
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
        tmo_d   = tmo_load_q;
`endif
      end
      ST_ISSUE: if (i_burst_ready) begin
        state_d = ST_WAIT;
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
        tmo_d   = tmo_load_q;
      end else if (tmo_q <= 32'd1) begin
        status_d = STAT_TIMEOUT;
        state_d  = ST_DONE;
      end else begin
        tmo_d = tmo_q - 32'd1;
`endif
      end
      ST_WAIT: if (i_burst_done) begin
        if (i_burst_resp[1]) begin
          status_d = (i_burst_resp == RESP_SLVERR) ? STAT_SLVERR : STAT_DECERR;
          state_d  = ST_DONE;
        end else begin
          rem_d   = rem_q - 32'(cur_beats);
          beats_d = beats_q + 32'(cur_beats);
          if (inc_q) addr_d = addr_q + (ADDR_WIDTH'(cur_beats) << BPB_LOG2);
          state_d = (rem_q == 32'(cur_beats)) ? ST_DONE : ST_CALC;
        end
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
      end else if (tmo_q <= 32'd1) begin
        status_d = STAT_TIMEOUT;
        state_d  = ST_DONE;
      end else begin
        tmo_d = tmo_q - 32'd1;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      write_q  <= 1'b0;
      inc_q    <= 1'b1;
      status_q <= STAT_OK;
      beats_q  <= '0;
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
      tmo_load_q <= '0;
      tmo_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      write_q  <= write_d;
      inc_q    <= inc_d;
      status_q <= status_d;
      beats_q  <= beats_d;
`ifdef AXI_BURST_SEQ_TIMEOUT_EN
      tmo_load_q <= tmo_load_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign o_cmd_rdy     = (state_q == ST_IDLE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_burst_valid = (state_q == ST_ISSUE);
  assign o_done_stb    = (state_q == ST_DONE);
  assign o_burst_addr  = addr_q;
  assign o_burst_len   = blen_q;
  assign o_burst_type  = inc_q ? BURST_INCR : BURST_FIXED;
  assign o_burst_write = write_q;
  assign o_status      = status_q;
  assign o_beats_done  = beats_q;

endmodule

// File: tb/tb_axi_burst_sequencer.sv
// Self-checking bench: directed table, hand sequences for zero-count, reset
// mid-transfer and (when compiled in) timeout, plus randomized transfers.
module tb_axi_burst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_stb, i_cmd_write, i_cmd_auto_inc;
  logic [31:0] i_cmd_addr, i_cmd_count, i_timeout;
  logic        o_cmd_rdy, o_burst_valid, i_burst_ready, o_burst_write;
  logic [31:0] o_burst_addr;
  logic [3:0]  o_burst_len;
  logic [1:0]  o_burst_type;
  logic        i_burst_done;
  logic [1:0]  i_burst_resp;
  logic        o_busy, o_done_stb;
  logic [1:0]  o_status;
  logic [31:0] o_beats_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_sequencer dut (
    .clk(clk), .rst(rst),
    .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_count(i_cmd_count), .i_cmd_auto_inc(i_cmd_auto_inc),
    .i_timeout(i_timeout), .o_burst_valid(o_burst_valid), .i_burst_ready(i_burst_ready),
    .o_burst_write(o_burst_write), .o_burst_addr(o_burst_addr), .o_burst_len(o_burst_len),
    .o_burst_type(o_burst_type), .i_burst_done(i_burst_done), .i_burst_resp(i_burst_resp),
    .o_busy(o_busy), .o_done_stb(o_done_stb), .o_status(o_status), .o_beats_done(o_beats_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  typ;
    logic        wr;
  } burst_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] count;
    logic        inc;
    int          err_idx;
    logic [1:0]  err_resp;
    logic [1:0]  exp_status;
    logic [31:0] exp_beats;
    int          exp_nb;
    logic [31:0] exp_last_addr;
    logic [3:0]  exp_last_len;
  } vec_t;

  burst_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Builds bursts beat by beat: a burst closes at 16 beats, when the request
  // is exhausted, or (INCR only) when the next beat would start a new 4 KB page.
  task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] count,
                       input logic inc);
    logic [31:0] a, rem, nxt;
    int n;
    burst_t b;
    exp_q.delete();
    a = addr;
    rem = count;
    while (rem != 0) begin
      n = 0;
      do begin
        n++;
        rem--;
        nxt = a + 32'(4 * n);
      end while (rem != 0 && n < 16 && !(inc && nxt[11:0] == 12'h000));
      b.addr = a; b.len = 4'(n - 1); b.typ = inc ? 2'b01 : 2'b00; b.wr = wr;
      exp_q.push_back(b);
      if (inc) a = a + 32'(4 * n);
    end
  endtask

  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] count,
                          input logic inc, input int err_idx, input logic [1:0] err_resp,
                          output logic [1:0] st, output logic [31:0] bd, output int nb,
                          output logic [31:0] last_addr, output logic [3:0] last_len);
    int t, first_valid, done_t, dly, exp_nb;
    logic pending, finished;
    logic [1:0] resp_now, exp_st;
    logic [31:0] exp_bd;
    model(wr, addr, count, inc);
    exp_nb = (err_idx >= 0 && err_idx < exp_q.size()) ? err_idx + 1 : exp_q.size();
    exp_st = 2'b00;
    exp_bd = 0;
    for (int k = 0; k < exp_nb; k++) begin
      if (k == err_idx) exp_st = (err_resp == 2'b10) ? 2'b01 : 2'b10;
      else exp_bd = exp_bd + 32'(exp_q[k].len) + 1;
    end
    st = 2'bxx; bd = 'x; nb = 0; last_addr = 'x; last_len = 'x;
    chk("cmd_rdy_idle", o_cmd_rdy, 1);
    i_cmd_stb = 1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_count = count;
    i_cmd_auto_inc = inc;
    @(negedge clk);
    i_cmd_stb = 0;
    t = 1; first_valid = -1; done_t = -1; pending = 0; finished = 0; dly = 0;
    resp_now = 2'b00;
    while (!finished && t < 3000) begin
      i_burst_done = 0;
      i_burst_ready = 0;
      // Garbage command traffic while busy must be ignored
      i_cmd_addr = $urandom; i_cmd_count = $urandom; i_cmd_write = 1'($urandom);
      i_cmd_auto_inc = 1'($urandom);
      i_cmd_stb = o_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (o_done_stb) begin
        st = o_status; bd = o_beats_done; done_t = t; finished = 1; i_cmd_stb = 0;
      end else if (o_burst_valid) begin
        if (first_valid < 0) first_valid = t;
        if ($urandom_range(0, 2) != 0) begin
          if (nb < exp_q.size()) begin
            chk("burst_addr", o_burst_addr, exp_q[nb].addr);
            chk("burst_len", o_burst_len, exp_q[nb].len);
            chk("burst_type", o_burst_type, exp_q[nb].typ);
            chk("burst_write", o_burst_write, exp_q[nb].wr);
          end else begin
            chk("extra_burst", 1, 0);
          end
          last_addr = o_burst_addr; last_len = o_burst_len;
          resp_now = (nb == err_idx) ? err_resp : 2'($urandom_range(0, 1));
          nb++;
          i_burst_ready = 1; pending = 1; dly = $urandom_range(0, 3);
        end
      end else if (pending) begin
        if (dly == 0) begin
          i_burst_done = 1; i_burst_resp = resp_now; pending = 0;
        end else dly--;
      end else if ($urandom_range(0, 4) == 0) begin
        i_burst_done = 1; i_burst_resp = 2'b11;
      end
      @(negedge clk);
      t++;
    end
    i_cmd_stb = 0; i_burst_done = 0; i_burst_ready = 0;
    if (!finished) chk("xfer_done_timeout", 0, 1);
    if (count != 0) chk("first_valid_lat", 64'(first_valid), 2);
    else begin
      chk("zero_no_valid", 64'(first_valid), 64'(-1));
      chk("zero_done_lat", 64'(done_t), 2);
    end
    chk("burst_count", 64'(nb), 64'(exp_nb));
    chk("model_status", st, exp_st);
    chk("model_beats", bd, exp_bd);
    chk("idle_after", {o_busy, o_cmd_rdy, o_done_stb}, 3'b010);
  endtask

  vec_t tbl[8];

  initial begin
    logic [1:0] st;
    logic [31:0] bd, la, a;
    logic [3:0] ll;
    int nb, vc;

    tbl[0] = '{1'b1, 32'h0000_1000, 32'd40, 1'b1, -1, 2'b00, 2'b00, 32'd40, 3, 32'h0000_1080, 4'd7};
    tbl[1] = '{1'b0, 32'h0000_0FF8, 32'd8,  1'b1, -1, 2'b00, 2'b00, 32'd8,  2, 32'h0000_1000, 4'd5};
    tbl[2] = '{1'b1, 32'h0000_2000, 32'd20, 1'b0, -1, 2'b00, 2'b00, 32'd20, 2, 32'h0000_2000, 4'd3};
    tbl[3] = '{1'b1, 32'h0000_1000, 32'd40, 1'b1,  1, 2'b10, 2'b01, 32'd16, 2, 32'h0000_1040, 4'd15};
    tbl[4] = '{1'b0, 32'h0000_3000, 32'd5,  1'b1,  0, 2'b11, 2'b10, 32'd0,  1, 32'h0000_3000, 4'd4};
    tbl[5] = '{1'b0, 32'hFFFF_FFF0, 32'd8,  1'b1, -1, 2'b00, 2'b00, 32'd8,  2, 32'h0000_0000, 4'd3};
    tbl[6] = '{1'b1, 32'h0000_1FC0, 32'd16, 1'b1, -1, 2'b00, 2'b00, 32'd16, 1, 32'h0000_1FC0, 4'd15};
    tbl[7] = '{1'b1, 32'h0000_5FFC, 32'd3,  1'b0, -1, 2'b00, 2'b00, 32'd3,  1, 32'h0000_5FFC, 4'd2};

    rst = 1; i_cmd_stb = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_count = 0;
    i_cmd_auto_inc = 1; i_timeout = 0; i_burst_ready = 0; i_burst_done = 0; i_burst_resp = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", {o_cmd_rdy, o_burst_valid, o_busy, o_done_stb}, 4'b1000);
    chk("rst_desc", {o_burst_addr, o_burst_len, o_burst_type, o_burst_write}, {32'h0, 4'h0, 2'b01, 1'b0});
    chk("rst_stat", {o_status, o_beats_done}, 34'h0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i].wr, tbl[i].addr, tbl[i].count, tbl[i].inc, tbl[i].err_idx,
               tbl[i].err_resp, st, bd, nb, la, ll);
      chk($sformatf("tbl%0d_status", i), st, tbl[i].exp_status);
      chk($sformatf("tbl%0d_beats", i), bd, tbl[i].exp_beats);
      chk($sformatf("tbl%0d_nb", i), 64'(nb), 64'(tbl[i].exp_nb));
      chk($sformatf("tbl%0d_last", i), {la, ll}, {tbl[i].exp_last_addr, tbl[i].exp_last_len});
      @(negedge clk);
    end

    // Zero-count request: done two cycles after accept, nothing issued
    i_cmd_stb = 1; i_cmd_count = 0; i_cmd_addr = 32'h100; i_cmd_auto_inc = 1;
    @(negedge clk);
    i_cmd_stb = 0;
    chk("zero_t1", {o_done_stb, o_burst_valid, o_busy}, 3'b001);
    @(negedge clk);
    chk("zero_t2", {o_done_stb, o_burst_valid, o_status, o_beats_done}, {1'b1, 1'b0, 2'b00, 32'd0});
    @(negedge clk);
    chk("zero_t3", {o_done_stb, o_busy, o_cmd_rdy}, 3'b001);

    // Reset during the second burst's WAIT
    i_cmd_stb = 1; i_cmd_write = 1; i_cmd_addr = 32'h1000; i_cmd_count = 40; i_cmd_auto_inc = 0;
    @(negedge clk);
    i_cmd_stb = 0;
    @(negedge clk);
    chk("rst_seq_valid1", o_burst_valid, 1);
    i_burst_ready = 1;
    @(negedge clk);
    i_burst_ready = 0; i_burst_done = 1; i_burst_resp = 2'b00;
    @(negedge clk);
    i_burst_done = 0;
    chk("rst_seq_beats16", o_beats_done, 32'd16);
    @(negedge clk);
    chk("rst_seq_valid2", {o_burst_valid, o_burst_type, o_burst_addr}, {1'b1, 2'b00, 32'h1000});
    i_burst_ready = 1;
    @(negedge clk);
    i_burst_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_state", {o_cmd_rdy, o_burst_valid, o_busy, o_done_stb}, 4'b1000);
    chk("midrst_desc", {o_burst_addr, o_burst_len, o_burst_type, o_burst_write}, {32'h0, 4'h0, 2'b01, 1'b0});
    chk("midrst_stat", {o_status, o_beats_done}, 34'h0);
    vc = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done_stb || o_busy) vc++;
    end
    chk("midrst_quiet", 64'(vc), 0);

`ifdef AXI_BURST_SEQ_TIMEOUT_EN
    // Engine never takes the descriptor: abort after 50 ISSUE cycles
    i_timeout = 50;
    i_cmd_stb = 1; i_cmd_write = 1; i_cmd_addr = 0; i_cmd_count = 40; i_cmd_auto_inc = 1;
    @(negedge clk);
    i_cmd_stb = 0;
    vc = 0;
    for (int k = 0; k < 200 && !o_done_stb; k++) begin
      @(negedge clk);
      if (o_burst_valid) vc++;
    end
    chk("tmo_done", o_done_stb, 1);
    chk("tmo_issue_cycles", 64'(vc), 50);
    chk("tmo_status", {o_status, o_beats_done}, {2'b11, 32'd0});
    i_burst_done = 1; i_burst_resp = 2'b10;
    @(negedge clk);
    i_burst_done = 0;
    chk("tmo_idle", {o_cmd_rdy, o_busy, o_status}, {1'b1, 1'b0, 2'b11});
    i_timeout = 0;
`endif

    // Randomized transfers, often placed just below a 4 KB page end
    for (int r = 0; r < 30; r++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) a = {a[31:12], 12'hFFC - 12'(4 * $urandom_range(0, 20))};
      run_xfer(1'($urandom), a, 32'($urandom_range(0, 70)), 1'($urandom),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1,
               2'($urandom_range(2, 3)), st, bd, nb, la, ll);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
